// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM states and rw encodings for the memory access controller
package mem_pkg;

    localparam int WORD_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int NUM_WORDS = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } mem_state_e;

endpackage

// File: rtl/addr_decoder_3to8.sv
// rtl/addr_decoder_3to8.sv - combinational row index to one-hot row select
module addr_decoder_3to8
    import mem_pkg::*;
(
    input  logic [ADDR_W-1:0]    idx,
    output logic [NUM_WORDS-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences one read/write per request onto the 8 word rows with setup, strobe and hold phases
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [WORD_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_write,
    output logic [WORD_W-1:0]           rsp_rdata,
    output logic [NUM_WORDS-1:0]        mem_sel,
    output logic                        mem_rw,
    output logic [WORD_W-1:0]           mem_word_in,
    input  logic [NUM_WORDS*WORD_W-1:0] mem_word_out
);

    localparam int              CNT_W       = 4;
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

    mem_state_e           state;
    logic [ADDR_W-1:0]    addr_q;
    logic                 wr_q;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_WORDS-1:0] dec_sel;
    logic [WORD_W-1:0]    rd_word;

    addr_decoder_3to8 u_dec (
        .idx    (addr_q),
        .onehot (dec_sel)
    );

    assign rd_word = mem_word_out[WORD_W*addr_q +: WORD_W];

    // mem_word_in is loaded at accept and doubles as the write-data holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            wr_q        <= RW_READ;
            cnt         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            mem_sel     <= '0;
            mem_rw      <= RW_READ;
            mem_word_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q      <= req_addr;
                        wr_q        <= req_write;
                        mem_rw      <= req_write ? RW_WRITE : RW_READ;
                        mem_word_in <= req_write ? req_wdata : '0;
                        req_ready   <= 1'b0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    mem_sel <= dec_sel;
                    cnt     <= STROBE_LOAD;
                    state   <= STROBE;
                end
                STROBE: begin
                    if (cnt == '0) begin
                        mem_sel   <= '0;
                        rsp_rdata <= wr_q ? '0 : rd_word;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    rsp_valid <= 1'b1;
                    rsp_write <= wr_q;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        mem_rw      <= RW_READ;
                        mem_word_in <= '0;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mem_sel   <= '0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl against a word-array reference model
module tb_mem_access_ctrl;

    localparam int S1 = 1;

    logic        clk;
    logic        rst;
    int          cyc;
    int          checks;
    int          errors;

    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [7:0]  rsp_rdata;
    logic [7:0]  mem_sel;
    logic        mem_rw;
    logic [7:0]  mem_word_in;
    logic [63:0] mem_word_out;

    logic        v4, ready4, w4, rv4, rr4, rw4;
    logic [2:0]  a4;
    logic [7:0]  d4, rd4, sel4, mwi4;
    logic        mrw4;
    logic [63:0] mwo4;

    mem_access_ctrl u_dut (
        .clk (clk), .rst (rst),
        .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata), .mem_sel (mem_sel), .mem_rw (mem_rw),
        .mem_word_in (mem_word_in), .mem_word_out (mem_word_out)
    );

    mem_access_ctrl #(.STROBE_CYCLES(4)) u_dut4 (
        .clk (clk), .rst (rst),
        .req_valid (v4), .req_ready (ready4), .req_write (w4),
        .req_addr (a4), .req_wdata (d4),
        .rsp_valid (rv4), .rsp_ready (rr4), .rsp_write (rw4),
        .rsp_rdata (rd4), .mem_sel (sel4), .mem_rw (mrw4),
        .mem_word_in (mwi4), .mem_word_out (mwo4)
    );

    // Word-row array driven by the controller, as the MemoryCell rows would behave
    logic [7:0] rows [8] = '{default: 8'h00};
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++)
            if (mem_sel[k] && mem_rw) rows[k] <= mem_word_in;
    end
    always_comb begin
        mem_word_out = '0;
        for (int k = 0; k < 8; k++) mem_word_out[8*k +: 8] = rows[k];
    end

    typedef struct {
        logic       wr;
        logic [7:0] rdata;
        int         acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] shadow [8] = '{default: 8'h00};
    int         stall;
    logic       busy;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall > 0) begin
                rsp_ready = 1'b0;
                stall--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: expected response popped on the first visible rsp_valid of each access
    initial begin
        logic       cur_w, cap_w, seen, pend;
        logic [2:0] cur_a;
        logic [7:0] cur_d, cap_d;
        int         nsel, hs_cyc;
        exp_t       e;
        busy = 1'b0; pend = 1'b0; seen = 1'b0; nsel = 0; hs_cyc = 0;
        cur_w = 1'b0; cur_a = '0; cur_d = '0; cap_w = 1'b0; cap_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 1'b0;
                pend = 1'b0;
                continue;
            end
            if (!busy) begin
                chk("idle_req_ready", req_ready, 1);
                chk("idle_mem_sel", mem_sel, 0);
                chk("idle_mem_rw", mem_rw, 0);
                chk("idle_mem_word_in", mem_word_in, 0);
                chk("idle_rsp_valid", rsp_valid, 0);
                if (req_valid && req_ready) begin
                    if (pend) chk("b2b_accept_cycle", cyc, hs_cyc + 1);
                    busy = 1'b1; pend = 1'b0; seen = 1'b0; nsel = 0;
                    cur_w = req_write; cur_a = req_addr; cur_d = req_wdata;
                end
            end else begin
                chk("busy_req_ready", req_ready, 0);
                chk("busy_mem_rw", mem_rw, cur_w);
                chk("busy_mem_word_in", mem_word_in, cur_w ? cur_d : 8'h00);
                if (mem_sel != 8'h00) begin
                    nsel++;
                    chk("strobe_mem_sel", mem_sel, 64'd1 << cur_a);
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        cap_w = rsp_write;
                        cap_d = rsp_rdata;
                        if (q.size() == 0) begin
                            chk("rsp_unexpected", 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk("rsp_write", rsp_write, e.wr);
                            chk("rsp_rdata", rsp_rdata, e.rdata);
                            chk("rsp_latency", cyc, e.acc + 3 + S1);
                        end
                    end else begin
                        chk("stall_rsp_write", rsp_write, cap_w);
                        chk("stall_rsp_rdata", rsp_rdata, cap_d);
                    end
                    if (rsp_ready) begin
                        chk("strobe_cycles", nsel, S1);
                        busy = 1'b0;
                        hs_cyc = cyc;
                        pend = req_valid;
                    end
                end
            end
        end
    end

    task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d);
        exp_t e;
        int   n;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            chk("send_accept_timeout", 0, 1);
            req_valid = 1'b0;
        end else begin
            e.wr = w;
            e.rdata = w ? 8'h00 : shadow[a];
            e.acc = cyc;
            if (w) shadow[a] = d;
            q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int acc, first, nsel4, n, seen_rv;
        checks = 0; errors = 0; stall = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        v4 = 1'b0; w4 = 1'b0; a4 = '0; d4 = '0; rr4 = 1'b1;
        mwo4 = 64'h1122334455667788;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_write", rsp_write, 0);
        chk("reset_mem_sel", mem_sel, 0);
        chk("reset_mem_rw", mem_rw, 0);
        chk("reset_mem_word_in", mem_word_in, 0);
        rst = 1'b0;
        @(negedge clk);

        // STROBE_CYCLES=4: read row 0
        v4 = 1'b1; w4 = 1'b0; a4 = 3'd0; d4 = 8'h3c;
        acc = cyc;
        chk("s4_accept_ready", ready4, 1);
        @(posedge clk);
        #1 v4 = 1'b0;
        nsel4 = 0; first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel4 != 8'h00) begin
                nsel4++;
                chk("s4_mem_sel", sel4, 8'h01);
            end
            if (rv4 && first < 0) begin
                first = cyc;
                chk("s4_rsp_rdata", rd4, 8'h88);
                chk("s4_rsp_write", rw4, 0);
            end
        end
        chk("s4_strobe_cycles", nsel4, 4);
        chk("s4_rsp_latency", first, acc + 7);

        // Reset in the 2nd strobe cycle of a write
        v4 = 1'b1; w4 = 1'b1; a4 = 3'd6; d4 = 8'h5a;
        @(posedge clk);
        #1 v4 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sel4 == 8'h00 && n < 10);
        chk("s4_strobe_reached", sel4, 8'h40);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_mem_sel", sel4, 0);
        chk("midrst_rsp_valid", rv4, 0);
        chk("midrst_mem_rw", mrw4, 0);
        chk("midrst_mem_word_in", mwi4, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", ready4, 1);
        seen_rv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv4 || sel4 != 8'h00) seen_rv = 1;
        end
        chk("midrst_no_response", seen_rv, 0);

        // Directed write/read of row 5 on the default-strobe controller
        @(posedge clk);
        #1;
        send(1'b1, 3'd5, 8'hA5);
        req_valid = 1'b0;
        send(1'b0, 3'd5, 8'h00);
        req_valid = 1'b0;

        // Back-to-back with the first response stalled
        repeat (3) @(posedge clk);
        #1;
        stall = 9;
        send(1'b1, 3'd2, 8'h3C);
        send(1'b0, 3'd2, 8'h00);
        req_valid = 1'b0;

        for (int i = 0; i < 80; i++) begin
            send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) != 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;

        n = 0;
        while ((busy || q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller that sits directly upstream of the eight MemoryCell word rows of the 8x8 memory array. It accepts one read or write request at a time over a valid/ready handshake and decodes the 3-bit address into the one-hot row `sel`. It drives `rw` and `wordIn` with setup, strobe and hold phases, muxes the selected row's `wordOut` back, and returns a response over a second valid/ready handshake.

## Interface
Parameters:
- `STROBE_CYCLES`, default 1: number of cycles `sel` is held high per access; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  3  word row index 0..7.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_write`  out  1  echo of the request's `req_write`.
- `rsp_rdata`  out  8  read data; 0 for writes.
- `mem_sel`  out  8  one-hot row select, one bit per MemoryCell `sel`.
- `mem_rw`  out  1  shared `rw` to all rows; 1 = write, 0 = read.
- `mem_word_in`  out  8  shared `wordIn` bus.
- `mem_word_out`  in  64  concatenated row `wordOut`; row k occupies bits [8k+7:8k].

## Operation
- FSM states are IDLE, SETUP, STROBE, HOLD and RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready`, latch addr, write flag and wdata, then go to SETUP.
- SETUP:
  - `mem_rw` = latched write flag.
  - `mem_word_in` = wdata for writes, 0 for reads.
  - `mem_sel` = 0.
  - Lasts 1 cycle, then STROBE.
- STROBE:
  - `mem_sel` = one-hot(addr); `mem_rw` and `mem_word_in` are unchanged.
  - A down-counter loaded with `STROBE_CYCLES-1` keeps the FSM here for exactly `STROBE_CYCLES` cycles.
  - Reads: on the edge leaving STROBE, register `mem_word_out[8*addr +: 8]` into `rsp_rdata`.
- HOLD:
  - `mem_sel` = 0; `mem_rw` and `mem_word_in` are still held, giving write hold time.
  - Lasts 1 cycle, then RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_write` and `rsp_rdata` are stable.
  - Stays in RESP until `rsp_ready`. On the handshake edge go to IDLE and drive `mem_rw`/`mem_word_in` to 0.
- `req_ready` is 1 only in IDLE. Requests presented in any other state are not accepted and must be held by the source.
- `mem_sel` is never multi-hot and is never high outside STROBE.

## Timing
- All outputs are registered. There are no combinational paths from any input to any output.
- Reset (async, any state, including mid-STROBE):
  - State = IDLE.
  - `mem_sel` = 0, `mem_rw` = 0, `mem_word_in` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_write` = 0.
  - `req_ready` = 1 after reset deasserts.
  - An interrupted access returns no response. A write interrupted mid-STROBE leaves the row contents undefined.
- Latency, with the accept edge as E0:
  - SETUP is the cycle after E0.
  - STROBE occupies the next `STROBE_CYCLES` cycles.
  - HOLD is 1 cycle.
  - `rsp_valid` rises after edge E(2+STROBE_CYCLES); with the default this is 3 cycles after accept.
- Throughput: one access per `4+STROBE_CYCLES` cycles when `rsp_ready` is tied high. IDLE always occupies at least one cycle between accesses.
- `rsp_ready` asserted before `rsp_valid` has no effect. Backpressure in RESP holds all response outputs stable.
- The read sample point is the last STROBE edge; `mem_word_out` must be valid by then.

## Structure
- Package `mem_pkg`:
  - `WORD_W`=8, `ADDR_W`=3, `NUM_WORDS`=8.
  - FSM state enum `mem_state_e`.
  - `rw` encodings `RW_READ`=0, `RW_WRITE`=1.
- Sub-module `addr_decoder_3to8`: combinational, 3-bit index to 8-bit one-hot. Its output is gated and registered in `mem_access_ctrl` so that it reaches `mem_sel` only during STROBE.
- The read mux stays inline.

## Test plan
- Reset mid-STROBE (`STROBE_CYCLES`=3, assert `rst` in the 2nd strobe cycle) -> `mem_sel`=0 immediately, no `rsp_valid`, `req_ready`=1 after deassert.
- Write addr 5, data 8'hA5 -> `mem_rw`=1 in SETUP..HOLD; `mem_sel`=8'b0010_0000 for exactly 1 cycle; `rsp_valid` 3 cycles after accept with `rsp_write`=1, `rsp_rdata`=0.
- Read addr 5 with `mem_word_out[47:40]`=8'hA5 and all other rows 8'h00 -> `rsp_rdata`=8'hA5, `mem_rw`=0, `mem_word_in`=0.
- `STROBE_CYCLES`=4, read addr 0 -> `mem_sel`=8'b0000_0001 for 4 cycles; `rsp_valid` 6 cycles after accept.
- Back-to-back requests with `rsp_ready` low for 5 cycles -> second request not accepted until the response handshake plus one IDLE cycle; response outputs stable during the stall.
